regfile_sequencer: RTL and testbench

REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

---
 rtl/regfile_seq_pkg.sv | 21 ++
 rtl/regfile_sequencer_operand_capture.sv | 41 ++++
 rtl/regfile_sequencer.sv | 110 +++++++++++
 tb/tb_regfile_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_seq_pkg.sv
// Shared types and constants for the register-file sequencer.
// Optional immediate operand path is enabled by IMM_OPERAND_EN.
package regfile_seq_pkg;

  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_REG_WIDTH  = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;

endpackage

// File: rtl/regfile_sequencer_operand_capture.sv
// Operand registers for the sequencer, with optional immediate mux
// on the second operand (IMM_OPERAND_EN).
module operand_capture
  import regfile_seq_pkg::*;
#(
  parameter int REG_WIDTH = DEF_REG_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 capture,
  input  logic [REG_WIDTH-1:0] bus_1,
  input  logic [REG_WIDTH-1:0] bus_2,
`ifdef IMM_OPERAND_EN
  input  logic                 use_imm,
  input  logic [REG_WIDTH-1:0] imm,
`endif
  output logic [REG_WIDTH-1:0] op_a,
  output logic [REG_WIDTH-1:0] op_b
);

  logic [REG_WIDTH-1:0] a_q;
  logic [REG_WIDTH-1:0] b_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
    end else if (capture) begin
      a_q <= bus_1;
      b_q <= bus_2;
    end
  end

  assign op_a = a_q;
`ifdef IMM_OPERAND_EN
  assign op_b = use_imm ? imm : b_q;
`else
  assign op_b = b_q;
`endif

endmodule

// File: rtl/regfile_sequencer.sv
// Four-state sequencer: read two registers, run the external ALU, write back.
// Build with IMM_OPERAND_EN to allow an immediate as the second operand.
module regfile_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int REG_WIDTH  = DEF_REG_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [2:0]            instr_op,
  input  logic [ADDR_WIDTH-1:0] instr_rd,
  input  logic [ADDR_WIDTH-1:0] instr_rs1,
  input  logic [ADDR_WIDTH-1:0] instr_rs2,
`ifdef IMM_OPERAND_EN
  input  logic                  instr_use_imm,
  input  logic [REG_WIDTH-1:0]  instr_imm,
`endif
  output logic [ADDR_WIDTH-1:0] rf_read_1_addr,
  output logic [ADDR_WIDTH-1:0] rf_read_2_addr,
  input  logic [REG_WIDTH-1:0]  rf_read_bus_1,
  input  logic [REG_WIDTH-1:0]  rf_read_bus_2,
  output logic [ADDR_WIDTH-1:0] rf_write_addr,
  output logic [REG_WIDTH-1:0]  rf_write_bus,
  output logic                  rf_write_enabled,
  output logic [REG_WIDTH-1:0]  alu_a,
  output logic [REG_WIDTH-1:0]  alu_b,
  output logic [2:0]            alu_op,
  input  logic [REG_WIDTH-1:0]  alu_result,
  output logic                  done
);

  state_t                state;
  logic [2:0]            op_q;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic [ADDR_WIDTH-1:0] rs1_q;
  logic [ADDR_WIDTH-1:0] rs2_q;
  logic [REG_WIDTH-1:0]  res_q;
`ifdef IMM_OPERAND_EN
  logic                  use_imm_q;
  logic [REG_WIDTH-1:0]  imm_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      op_q  <= '0;
      rd_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      res_q <= '0;
`ifdef IMM_OPERAND_EN
      use_imm_q <= 1'b0;
      imm_q     <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (instr_valid) begin
            op_q  <= instr_op;
            rd_q  <= instr_rd;
            rs1_q <= instr_rs1;
            rs2_q <= instr_rs2;
`ifdef IMM_OPERAND_EN
            use_imm_q <= instr_use_imm;
            imm_q     <= instr_imm;
`endif
            state <= S_READ;
          end
        end
        S_READ:  state <= S_EXEC;
        S_EXEC: begin
          res_q <= alu_result;
          state <= S_WRITE;
        end
        S_WRITE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  operand_capture #(
    .REG_WIDTH(REG_WIDTH)
  ) u_operands (
    .clk     (clk),
    .reset   (reset),
    .capture (state == S_READ),
    .bus_1   (rf_read_bus_1),
    .bus_2   (rf_read_bus_2),
`ifdef IMM_OPERAND_EN
    .use_imm (use_imm_q),
    .imm     (imm_q),
`endif
    .op_a    (alu_a),
    .op_b    (alu_b)
  );

  // Addresses follow the latched fields; they only matter in READ/WRITE.
  assign instr_ready      = (state == S_IDLE);
  assign rf_read_1_addr   = rs1_q;
  assign rf_read_2_addr   = rs2_q;
  assign alu_op           = op_q;
  assign rf_write_addr    = rd_q;
  assign rf_write_bus     = res_q;
  assign rf_write_enabled = (state == S_WRITE);
  assign done             = (state == S_WRITE);

endmodule

// File: tb/tb_regfile_sequencer.sv
// Self-checking bench for regfile_sequencer: register-file and ALU
// models around the DUT, write-back scoreboard, vector table.
module tb_regfile_sequencer;
  import regfile_seq_pkg::*;

  localparam int AW = 3;
  localparam int RW = 16;
  localparam logic [RW-1:0] INIT [8] = '{
    16'h0000, 16'h0005, 16'h0003, 16'h0000,
    16'h00FF, 16'h0001, 16'h0000, 16'h1234
  };

  typedef struct {
    logic [2:0]    op;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [RW-1:0] exp;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [RW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          instr_valid;
  logic          instr_ready;
  logic [2:0]    instr_op;
  logic [AW-1:0] instr_rd;
  logic [AW-1:0] instr_rs1;
  logic [AW-1:0] instr_rs2;
`ifdef IMM_OPERAND_EN
  logic          instr_use_imm;
  logic [RW-1:0] instr_imm;
`endif
  logic [AW-1:0] rf_read_1_addr;
  logic [AW-1:0] rf_read_2_addr;
  logic [RW-1:0] rf_read_bus_1;
  logic [RW-1:0] rf_read_bus_2;
  logic [AW-1:0] rf_write_addr;
  logic [RW-1:0] rf_write_bus;
  logic          rf_write_enabled;
  logic [RW-1:0] alu_a;
  logic [RW-1:0] alu_b;
  logic [2:0]    alu_op;
  logic [RW-1:0] alu_result;
  logic          done;

  logic          rf_init;
  logic [RW-1:0] rf [8];
  logic [RW-1:0] ref_rf [8];
  wr_t           exp_q [$];
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  regfile_sequencer #(
    .ADDR_WIDTH(AW),
    .REG_WIDTH (RW)
  ) dut (
`ifdef IMM_OPERAND_EN
    .instr_use_imm   (instr_use_imm),
    .instr_imm       (instr_imm),
`endif
    .clk             (clk),
    .reset           (reset),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_op        (instr_op),
    .instr_rd        (instr_rd),
    .instr_rs1       (instr_rs1),
    .instr_rs2       (instr_rs2),
    .rf_read_1_addr  (rf_read_1_addr),
    .rf_read_2_addr  (rf_read_2_addr),
    .rf_read_bus_1   (rf_read_bus_1),
    .rf_read_bus_2   (rf_read_bus_2),
    .rf_write_addr   (rf_write_addr),
    .rf_write_bus    (rf_write_bus),
    .rf_write_enabled(rf_write_enabled),
    .alu_a           (alu_a),
    .alu_b           (alu_b),
    .alu_op          (alu_op),
    .alu_result      (alu_result),
    .done            (done)
  );

  function automatic logic [RW-1:0] alu_model(
    input logic [2:0] op, input logic [RW-1:0] a, input logic [RW-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return '0;
    endcase
  endfunction

  assign rf_read_bus_1 = rf[rf_read_1_addr];
  assign rf_read_bus_2 = rf[rf_read_2_addr];
  assign alu_result    = alu_model(alu_op, alu_a, alu_b);

  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 8; i++) rf[i] <= INIT[i];
    end else if (rf_write_enabled) begin
      rf[rf_write_addr] <= rf_write_bus;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every observed write must match the oldest expectation.
  always @(negedge clk) begin
    if (rf_write_enabled) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data %h",
                 rf_write_addr, rf_write_bus);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", 32'(rf_write_addr), 32'(e.addr));
        chk("write_data", 32'(rf_write_bus), 32'(e.data));
        chk("done_with_write", 32'(done), 32'd1);
      end
    end
  end

  task automatic run_instr(input logic [2:0] op, input logic [AW-1:0] rd,
                           input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                           input logic ui, input logic [RW-1:0] imm,
                           input logic [RW-1:0] exp, input int rst_at);
    logic [RW-1:0] ea;
    logic [RW-1:0] eb;
    @(negedge clk);
    chk("ready_idle", 32'(instr_ready), 32'd1);
    instr_op  = op;
    instr_rd  = rd;
    instr_rs1 = rs1;
    instr_rs2 = rs2;
`ifdef IMM_OPERAND_EN
    instr_use_imm = ui;
    instr_imm     = imm;
`endif
    instr_valid = 1'b1;
    ea = ref_rf[rs1];
    eb = ui ? imm : ref_rf[rs2];
    if (rst_at != 2) exp_q.push_back('{addr: rd, data: exp});
    @(posedge clk);
    #1 instr_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("busy_not_ready", 32'(instr_ready), 32'd0);
      chk("write_timing", 32'(rf_write_enabled), 32'(k == 3));
      chk("done_timing", 32'(done), 32'(k == 3));
      if (k == 1) begin
        chk("read_1_addr", 32'(rf_read_1_addr), 32'(rs1));
        chk("read_2_addr", 32'(rf_read_2_addr), 32'(rs2));
      end
      if (k == 2) begin
        chk("alu_a", 32'(alu_a), 32'(ea));
        chk("alu_b", 32'(alu_b), 32'(eb));
        chk("alu_op", 32'(alu_op), 32'(op));
      end
      if (k == rst_at) begin
        reset = 1'b1;
        break;
      end
    end
    if (rst_at != 0) begin
      @(negedge clk);
      chk("rst_ready", 32'(instr_ready), 32'd1);
      chk("rst_no_write", 32'(rf_write_enabled), 32'd0);
      chk("rst_no_done", 32'(done), 32'd0);
      chk("rst_alu_a", 32'(alu_a), 32'd0);
      chk("rst_write_bus", 32'(rf_write_bus), 32'd0);
      reset = 1'b0;
    end
    if (rst_at != 2) ref_rf[rd] = exp;
    ui = ui;
  endtask

  vec_t vecs [8];

  initial begin
    int acc;
    int low;
    vecs[0] = '{OP_ADD, 3'd3, 3'd1, 3'd2, 16'h0008};
    vecs[1] = '{OP_ADD, 3'd4, 3'd4, 3'd5, 16'h0100};
    vecs[2] = '{OP_SUB, 3'd6, 3'd0, 3'd5, 16'hFFFF};
    vecs[3] = '{OP_AND, 3'd0, 3'd7, 3'd6, 16'h1234};
    vecs[4] = '{OP_XOR, 3'd2, 3'd7, 3'd7, 16'h0000};
    vecs[5] = '{OP_OR,  3'd1, 3'd3, 3'd4, 16'h0108};
    vecs[6] = '{OP_ADD, 3'd7, 3'd6, 3'd6, 16'hFFFE};
    vecs[7] = '{OP_SUB, 3'd5, 3'd1, 3'd3, 16'h0100};
    for (int i = 0; i < 8; i++) ref_rf[i] = INIT[i];

    reset       = 1'b1;
    rf_init     = 1'b1;
    instr_valid = 1'b0;
    instr_op    = '0;
    instr_rd    = '0;
    instr_rs1   = '0;
    instr_rs2   = '0;
`ifdef IMM_OPERAND_EN
    instr_use_imm = 1'b0;
    instr_imm     = '0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 32'(instr_ready), 32'd1);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_we", 32'(rf_write_enabled), 32'd0);
    chk("reset_waddr", 32'(rf_write_addr), 32'd0);
    chk("reset_wbus", 32'(rf_write_bus), 32'd0);
    chk("reset_raddr1", 32'(rf_read_1_addr), 32'd0);
    chk("reset_raddr2", 32'(rf_read_2_addr), 32'd0);
    chk("reset_alu_a", 32'(alu_a), 32'd0);
    chk("reset_alu_b", 32'(alu_b), 32'd0);
    chk("reset_alu_op", 32'(alu_op), 32'd0);
    reset   = 1'b0;
    rf_init = 1'b0;

`ifdef IMM_OPERAND_EN
    run_instr(OP_ADD, 3'd6, 3'd5, 3'd7, 1'b1, 16'h1000, 16'h1001, 0);
`endif

    for (int i = 0; i < 8; i++) begin
      run_instr(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                1'b0, 16'h0000, vecs[i].exp, 0);
    end
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("regfile_r%0d", i), 32'(rf[i]), 32'(ref_rf[i]));
    end

    // Valid held high: one acceptance every fourth cycle.
    acc = 0;
    low = 0;
    instr_op    = OP_ADD;
    instr_rd    = 3'd1;
    instr_rs1   = 3'd1;
    instr_rs2   = 3'd5;
    instr_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (instr_ready) begin
        acc++;
        ref_rf[1] = alu_model(OP_ADD, ref_rf[1], ref_rf[5]);
        exp_q.push_back('{addr: 3'd1, data: ref_rf[1]});
      end else begin
        low++;
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk("burst_accepts", 32'(acc), 32'd3);
    chk("burst_not_ready", 32'(low), 32'd9);

    run_instr(OP_ADD, 3'd0, 3'd1, 3'd2, 1'b0, 16'h0000, 16'h0000, 2);
    run_instr(OP_ADD, 3'd2, 3'd4, 3'd5, 1'b0, 16'h0000, 16'h0200, 3);

    repeat (6) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("r1_after_burst", 32'(rf[1]), 32'(ref_rf[1]));
    chk("r2_after_rst_write", 32'(rf[2]), 32'h0200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
